// File: rtl/cve2_hwlp_ctrl_pkg.sv
// Shared types for the hardware-loop controller: register select and IF PC-mux encoding.
// Build option: CVE2_HWLP_COMPRESSED_EN enables half-word loop end/start addresses.
package cve2_pkg;

  typedef enum logic [1:0] {
    HWLP_START = 2'd0,
    HWLP_END   = 2'd1,
    HWLP_COUNT = 2'd2
  } hwlp_reg_e;

  typedef enum logic [2:0] {
    PC_BOOT = 3'd0,
    PC_JUMP = 3'd1,
    PC_EXC  = 3'd2,
    PC_ERET = 3'd3,
    PC_DRET = 3'd4,
    PC_BP   = 3'd5,
    PC_HWLP = 3'd6
  } pc_sel_e;

  // Address granularity for loop start/end storage and the end-of-loop match.
  function automatic logic [31:0] hwlp_addr_mask(input logic [31:0] addr);
`ifdef CVE2_HWLP_COMPRESSED_EN
    return {addr[31:1], 1'b0};
`else
    return {addr[31:2], 2'b00};
`endif
  endfunction

endpackage

// File: rtl/cve2_hwlp_ctrl_if.sv
// Fetch handshake between the IF stage and the hardware-loop controller, plus the redirect request.
interface cve2_hwlp_ctrl_if #(
  parameter int unsigned IdxWidth = 1
);
  logic                fetch_valid_i;
  logic                fetch_ready_i;
  logic [31:0]         fetch_addr_i;
  logic                flush_i;
  logic                hwlp_jump_o;
  logic [31:0]         hwlp_target_o;
  logic [IdxWidth-1:0] hwlp_idx_o;

  modport master (
    output fetch_valid_i, fetch_ready_i, fetch_addr_i, flush_i,
    input  hwlp_jump_o, hwlp_target_o, hwlp_idx_o
  );

  modport slave (
    input  fetch_valid_i, fetch_ready_i, fetch_addr_i, flush_i,
    output hwlp_jump_o, hwlp_target_o, hwlp_idx_o
  );
endinterface

// File: rtl/cve2_hwlp_channel.sv
// One hardware-loop channel: start/end/count registers and the end-of-loop hit detect.
// Build option: CVE2_HWLP_COMPRESSED_EN selects half-word address matching.
module cve2_hwlp_channel
  import cve2_pkg::*;
#(
  parameter int unsigned CntWidth = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cfg_we_i,
  input  hwlp_reg_e           cfg_sel_i,
  input  logic [31:0]         cfg_wdata_i,
  input  logic                accept_i,
  input  logic [31:0]         fetch_addr_i,
  input  logic                dec_i,
  output logic                hit_o,
  output logic [31:0]         start_o,
  output logic [31:0]         end_o,
  output logic [CntWidth-1:0] cnt_o
);

  logic [31:0]         start_reg;
  logic [31:0]         end_reg;
  logic [CntWidth-1:0] cnt_reg;
  logic                active;

  assign active = (cnt_reg != '0);
  assign hit_o  = accept_i && active && (hwlp_addr_mask(fetch_addr_i) == end_reg);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_reg <= '0;
      end_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      if (cfg_we_i && (cfg_sel_i == HWLP_START)) start_reg <= hwlp_addr_mask(cfg_wdata_i);
      if (cfg_we_i && (cfg_sel_i == HWLP_END))   end_reg   <= hwlp_addr_mask(cfg_wdata_i);
      // A software write of COUNT wins over the loop's own decrement.
      if (cfg_we_i && (cfg_sel_i == HWLP_COUNT)) begin
        cnt_reg <= cfg_wdata_i[CntWidth-1:0];
      end else if (dec_i && active) begin
        cnt_reg <= cnt_reg - CntWidth'(1);
      end
    end
  end

  assign start_o = start_reg;
  assign end_o   = end_reg;
  assign cnt_o   = cnt_reg;

endmodule

// File: rtl/cve2_hwlp_ctrl.sv
// Hardware-loop controller: per-channel registers, lowest-index hit priority, registered redirect.
// Build option: CVE2_HWLP_COMPRESSED_EN allows half-word loop end addresses.
module cve2_hwlp_ctrl
  import cve2_pkg::*;
#(
  parameter  int unsigned NumHwlp  = 2,
  parameter  int unsigned CntWidth = 32,
  localparam int unsigned IdxWidth = (NumHwlp > 1) ? $clog2(NumHwlp) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              cfg_we_i,
  input  logic [IdxWidth-1:0]               cfg_idx_i,
  input  hwlp_reg_e                         cfg_sel_i,
  input  logic [31:0]                       cfg_wdata_i,
  cve2_hwlp_ctrl_if.slave                   fetch_bus,
  output logic [NumHwlp-1:0][31:0]          hwlp_start_o,
  output logic [NumHwlp-1:0][31:0]          hwlp_end_o,
  output logic [NumHwlp-1:0][CntWidth-1:0]  hwlp_cnt_o
);

  logic                accept;
  logic [NumHwlp-1:0]  hit;
  logic [NumHwlp-1:0]  dec;
  logic                any_hit;
  logic [IdxWidth-1:0] sel_idx;
  logic                jump_next;
  logic                jump_reg;
  logic [31:0]         target_reg;
  logic [IdxWidth-1:0] idx_reg;

  assign accept = fetch_bus.fetch_valid_i & fetch_bus.fetch_ready_i & ~fetch_bus.flush_i;

  generate
    for (genvar gi = 0; gi < NumHwlp; gi++) begin : g_chan
      cve2_hwlp_channel #(
        .CntWidth(CntWidth)
      ) u_chan (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cfg_we_i    (cfg_we_i && (cfg_idx_i == IdxWidth'(gi))),
        .cfg_sel_i   (cfg_sel_i),
        .cfg_wdata_i (cfg_wdata_i),
        .accept_i    (accept),
        .fetch_addr_i(fetch_bus.fetch_addr_i),
        .dec_i       (dec[gi]),
        .hit_o       (hit[gi]),
        .start_o     (hwlp_start_o[gi]),
        .end_o       (hwlp_end_o[gi]),
        .cnt_o       (hwlp_cnt_o[gi])
      );
    end
  endgenerate

  // Innermost (lowest-index) channel wins when nested loops share an end address.
  always_comb begin
    any_hit = 1'b0;
    sel_idx = '0;
    for (int i = NumHwlp - 1; i >= 0; i--) begin
      if (hit[i]) begin
        any_hit = 1'b1;
        sel_idx = IdxWidth'(i);
      end
    end
  end

  always_comb begin
    dec = '0;
    if (any_hit) dec[sel_idx] = 1'b1;
  end

  assign jump_next = any_hit && (hwlp_cnt_o[sel_idx] >= CntWidth'(2));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      jump_reg   <= 1'b0;
      target_reg <= '0;
      idx_reg    <= '0;
    end else begin
      jump_reg <= jump_next;
      if (jump_next) begin
        target_reg <= hwlp_start_o[sel_idx];
        idx_reg    <= sel_idx;
      end
    end
  end

  // Masking with reset drops a jump that is already pending in the output register.
  assign fetch_bus.hwlp_jump_o   = jump_reg & ~rst_i;
  assign fetch_bus.hwlp_target_o = target_reg;
  assign fetch_bus.hwlp_idx_o    = idx_reg;

endmodule

// File: tb/tb_cve2_hwlp_ctrl.sv
// Directed self-checking bench for cve2_hwlp_ctrl (NumHwlp=2, CntWidth=32).
module tb_cve2_hwlp_ctrl;
  import cve2_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfg_we;
  logic [0:0]             cfg_idx;
  hwlp_reg_e              cfg_sel;
  logic [31:0]            cfg_wdata;
  logic [1:0][31:0]       start_rb;
  logic [1:0][31:0]       end_rb;
  logic [1:0][31:0]       cnt_rb;
  int                     errors = 0;
  int                     checks = 0;

  cve2_hwlp_ctrl_if #(.IdxWidth(1)) bus ();

  cve2_hwlp_ctrl #(.NumHwlp(2), .CntWidth(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .cfg_we_i    (cfg_we),
    .cfg_idx_i   (cfg_idx),
    .cfg_sel_i   (cfg_sel),
    .cfg_wdata_i (cfg_wdata),
    .fetch_bus   (bus),
    .hwlp_start_o(start_rb),
    .hwlp_end_o  (end_rb),
    .hwlp_cnt_o  (cnt_rb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input logic [0:0] idx, input hwlp_reg_e sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = data;
    tick();
    cfg_we = 1'b0;
    $display("cfg   ch=%0d sel=%s data=%h", idx, sel.name(), data);
  endtask

  task automatic setup_ch(input logic [0:0] idx, input logic [31:0] s, input logic [31:0] e,
                          input logic [31:0] c);
    cfg_write(idx, HWLP_START, s);
    cfg_write(idx, HWLP_END, e);
    cfg_write(idx, HWLP_COUNT, c);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic fl);
    bus.fetch_valid_i = 1'b1; bus.fetch_ready_i = 1'b1;
    bus.fetch_addr_i = addr; bus.flush_i = fl;
    tick();
    bus.fetch_valid_i = 1'b0; bus.flush_i = 1'b0;
    $display("fetch addr=%h flush=%b -> jump=%b target=%h idx=%0d cnt0=%0d cnt1=%0d",
             addr, fl, bus.hwlp_jump_o, bus.hwlp_target_o, bus.hwlp_idx_o, cnt_rb[0], cnt_rb[1]);
  endtask

  task automatic test_reset();
    do_reset();
    setup_ch(1'b0, 32'h100, 32'h10C, 32'd3);
    setup_ch(1'b1, 32'h300, 32'h10C, 32'd4);
    fetch(32'h10C, 1'b0);
    rst = 1'b1;
    tick();
    checks++; if (bus.hwlp_jump_o !== 1'b0) begin errors++; $display("FAIL reset_jump: got %b want 0", bus.hwlp_jump_o); end
    rst = 1'b0;
    checks++; if (bus.hwlp_target_o !== 32'h0) begin errors++; $display("FAIL reset_target: got %h want 0", bus.hwlp_target_o); end
    checks++; if (bus.hwlp_idx_o !== 1'b0) begin errors++; $display("FAIL reset_idx: got %0d want 0", bus.hwlp_idx_o); end
    checks++; if (start_rb !== '0) begin errors++; $display("FAIL reset_start: got %h want 0", start_rb); end
    checks++; if (end_rb !== '0) begin errors++; $display("FAIL reset_end: got %h want 0", end_rb); end
    checks++; if (cnt_rb !== '0) begin errors++; $display("FAIL reset_cnt: got %h want 0", cnt_rb); end
  endtask

  task automatic test_basic_loop();
    do_reset();
    setup_ch(1'b0, 32'h100, 32'h10C, 32'd3);
    for (int p = 1; p <= 3; p++) begin
      for (int a = 0; a < 3; a++) begin
        fetch(32'h100 + 32'(4 * a), 1'b0);
        checks++; if (bus.hwlp_jump_o !== 1'b0) begin errors++; $display("FAIL loop_body pass %0d: jump got %b want 0", p, bus.hwlp_jump_o); end
      end
      fetch(32'h10C, 1'b0);
      checks++; if (bus.hwlp_jump_o !== 1'(p < 3)) begin errors++; $display("FAIL loop_end_jump pass %0d: got %b want %b", p, bus.hwlp_jump_o, 1'(p < 3)); end
      if (p < 3) begin
        checks++; if (bus.hwlp_target_o !== 32'h100 || bus.hwlp_idx_o !== 1'b0) begin errors++; $display("FAIL loop_target pass %0d: got %h/%0d want 100/0", p, bus.hwlp_target_o, bus.hwlp_idx_o); end
      end
      checks++; if (cnt_rb[0] !== 32'(3 - p)) begin errors++; $display("FAIL loop_cnt pass %0d: got %0d want %0d", p, cnt_rb[0], 3 - p); end
    end
    fetch(32'h10C, 1'b0);
    checks++; if (bus.hwlp_jump_o !== 1'b0 || cnt_rb[0] !== 32'd0) begin errors++; $display("FAIL no_wrap: jump=%b cnt=%0d want 0/0", bus.hwlp_jump_o, cnt_rb[0]); end
  endtask

  task automatic test_nested();
    do_reset();
    setup_ch(1'b0, 32'h200, 32'h110, 32'd2);
    setup_ch(1'b1, 32'h300, 32'h110, 32'd5);
    fetch(32'h110, 1'b0);
    checks++; if (bus.hwlp_jump_o !== 1'b1 || bus.hwlp_idx_o !== 1'b0 || bus.hwlp_target_o !== 32'h200) begin errors++; $display("FAIL nested_inner: got jump=%b idx=%0d tgt=%h want 1/0/200", bus.hwlp_jump_o, bus.hwlp_idx_o, bus.hwlp_target_o); end
    checks++; if (cnt_rb[0] !== 32'd1 || cnt_rb[1] !== 32'd5) begin errors++; $display("FAIL nested_cnt: got %0d/%0d want 1/5", cnt_rb[0], cnt_rb[1]); end
    tick();
    checks++; if (bus.hwlp_jump_o !== 1'b0 || bus.hwlp_target_o !== 32'h200 || bus.hwlp_idx_o !== 1'b0) begin errors++; $display("FAIL hold_outputs: got jump=%b tgt=%h idx=%0d want 0/200/0", bus.hwlp_jump_o, bus.hwlp_target_o, bus.hwlp_idx_o); end
    fetch(32'h110, 1'b0);
    checks++; if (bus.hwlp_jump_o !== 1'b0 || cnt_rb[0] !== 32'd0 || cnt_rb[1] !== 32'd5) begin errors++; $display("FAIL nested_exit: got jump=%b cnt=%0d/%0d want 0 0/5", bus.hwlp_jump_o, cnt_rb[0], cnt_rb[1]); end
    fetch(32'h110, 1'b0);
    checks++; if (bus.hwlp_jump_o !== 1'b1 || bus.hwlp_idx_o !== 1'b1 || bus.hwlp_target_o !== 32'h300 || cnt_rb[1] !== 32'd4) begin errors++; $display("FAIL nested_outer: got jump=%b idx=%0d tgt=%h cnt1=%0d want 1/1/300/4", bus.hwlp_jump_o, bus.hwlp_idx_o, bus.hwlp_target_o, cnt_rb[1]); end
  endtask

  task automatic test_flush();
    do_reset();
    setup_ch(1'b0, 32'h100, 32'h10C, 32'd3);
    fetch(32'h10C, 1'b1);
    checks++; if (bus.hwlp_jump_o !== 1'b0 || cnt_rb[0] !== 32'd3) begin errors++; $display("FAIL flush_hit: got jump=%b cnt=%0d want 0/3", bus.hwlp_jump_o, cnt_rb[0]); end
    bus.fetch_valid_i = 1'b1; bus.fetch_ready_i = 1'b0; bus.fetch_addr_i = 32'h10C;
    tick();
    bus.fetch_valid_i = 1'b0; bus.fetch_ready_i = 1'b1;
    $display("fetch addr=010c stalled -> jump=%b cnt0=%0d", bus.hwlp_jump_o, cnt_rb[0]);
    checks++; if (bus.hwlp_jump_o !== 1'b0 || cnt_rb[0] !== 32'd3) begin errors++; $display("FAIL not_ready: got jump=%b cnt=%0d want 0/3", bus.hwlp_jump_o, cnt_rb[0]); end
    fetch(32'h10C, 1'b0);
    checks++; if (bus.hwlp_jump_o !== 1'b1 || cnt_rb[0] !== 32'd2) begin errors++; $display("FAIL flush_retry: got jump=%b cnt=%0d want 1/2", bus.hwlp_jump_o, cnt_rb[0]); end
    bus.flush_i = 1'b1;
    #1;
    checks++; if (bus.hwlp_jump_o !== 1'b1) begin errors++; $display("FAIL flush_during_jump: got %b want 1", bus.hwlp_jump_o); end
    tick();
    bus.flush_i = 1'b0;
    checks++; if (cnt_rb[0] !== 32'd2) begin errors++; $display("FAIL flush_no_restore: got %0d want 2", cnt_rb[0]); end
  endtask

  task automatic test_cfg_priority();
    do_reset();
    setup_ch(1'b0, 32'h100, 32'h10C, 32'd3);
    cfg_we = 1'b1; cfg_idx = 1'b0; cfg_sel = HWLP_COUNT; cfg_wdata = 32'd7;
    fetch(32'h10C, 1'b0);
    cfg_we = 1'b0;
    checks++; if (cnt_rb[0] !== 32'd7 || bus.hwlp_jump_o !== 1'b1 || bus.hwlp_target_o !== 32'h100) begin errors++; $display("FAIL cfg_count_prio: got cnt=%0d jump=%b tgt=%h want 7/1/100", cnt_rb[0], bus.hwlp_jump_o, bus.hwlp_target_o); end
    cfg_we = 1'b1; cfg_sel = HWLP_START; cfg_wdata = 32'h240;
    fetch(32'h10C, 1'b0);
    cfg_we = 1'b0;
    checks++; if (bus.hwlp_target_o !== 32'h100 || cnt_rb[0] !== 32'd6 || start_rb[0] !== 32'h240) begin errors++; $display("FAIL cfg_start_same_cycle: got tgt=%h cnt=%0d start=%h want 100/6/240", bus.hwlp_target_o, cnt_rb[0], start_rb[0]); end
    fetch(32'h10C, 1'b0);
    checks++; if (bus.hwlp_jump_o !== 1'b1 || bus.hwlp_target_o !== 32'h240) begin errors++; $display("FAIL cfg_start_next: got jump=%b tgt=%h want 1/240", bus.hwlp_jump_o, bus.hwlp_target_o); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    setup_ch(1'b0, 32'h100, 32'h10C, 32'd3);
    setup_ch(1'b1, 32'h300, 32'h400, 32'd9);
    fetch(32'h10C, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (bus.hwlp_jump_o !== 1'b0) begin errors++; $display("FAIL rst_drop_now: got %b want 0", bus.hwlp_jump_o); end
    tick();
    rst = 1'b0;
    checks++; if (bus.hwlp_jump_o !== 1'b0 || cnt_rb !== '0) begin errors++; $display("FAIL rst_drop_after: got jump=%b cnt=%h want 0/0", bus.hwlp_jump_o, cnt_rb); end
    tick();
    checks++; if (bus.hwlp_jump_o !== 1'b0) begin errors++; $display("FAIL rst_drop_later: got %b want 0", bus.hwlp_jump_o); end
  endtask

  task automatic test_compressed();
    do_reset();
    setup_ch(1'b0, 32'h100, 32'h112, 32'd3);
`ifdef CVE2_HWLP_COMPRESSED_EN
    checks++; if (end_rb[0] !== 32'h112) begin errors++; $display("FAIL halfword_end_rb: got %h want 112", end_rb[0]); end
    fetch(32'h110, 1'b0);
    checks++; if (bus.hwlp_jump_o !== 1'b0 || cnt_rb[0] !== 32'd3) begin errors++; $display("FAIL halfword_miss: got jump=%b cnt=%0d want 0/3", bus.hwlp_jump_o, cnt_rb[0]); end
    fetch(32'h112, 1'b0);
    checks++; if (bus.hwlp_jump_o !== 1'b1 || cnt_rb[0] !== 32'd2) begin errors++; $display("FAIL halfword_hit: got jump=%b cnt=%0d want 1/2", bus.hwlp_jump_o, cnt_rb[0]); end
`else
    checks++; if (end_rb[0] !== 32'h110) begin errors++; $display("FAIL word_end_rb: got %h want 110", end_rb[0]); end
    fetch(32'h10C, 1'b0);
    checks++; if (bus.hwlp_jump_o !== 1'b0 || cnt_rb[0] !== 32'd3) begin errors++; $display("FAIL word_miss: got jump=%b cnt=%0d want 0/3", bus.hwlp_jump_o, cnt_rb[0]); end
    fetch(32'h110, 1'b0);
    checks++; if (bus.hwlp_jump_o !== 1'b1 || cnt_rb[0] !== 32'd2 || bus.hwlp_target_o !== 32'h100) begin errors++; $display("FAIL word_hit: got jump=%b cnt=%0d tgt=%h want 1/2/100", bus.hwlp_jump_o, cnt_rb[0], bus.hwlp_target_o); end
`endif
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = 1'b0; cfg_sel = HWLP_START; cfg_wdata = '0;
    bus.fetch_valid_i = 1'b0; bus.fetch_ready_i = 1'b1; bus.fetch_addr_i = '0; bus.flush_i = 1'b0;
    tick();
    test_reset();
    test_basic_loop();
    test_nested();
    test_flush();
    test_cfg_priority();
    test_reset_pending();
    test_compressed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cve2_hwlp_ctrl.md
CVE2_HWLP_CTRL -- requirements
Module: cve2_hwlp_ctrl

Interface
REQ-001 SHALL have parameter NumHwlp, default 2, meaning number of hardware-loop channels (1..4); channel 0 is the innermost loop.
REQ-002 SHALL have parameter CntWidth, default 32, meaning width of each loop counter (2..32).
REQ-003 SHALL have port clk_i  input  1  clock; one clock domain.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cfg_we_i  input  1  configuration write strobe.
REQ-006 SHALL have port cfg_idx_i  input  $clog2(NumHwlp) (min 1)  channel select.
REQ-007 SHALL have port cfg_sel_i  input  hwlp_reg_e  register select: START/END/COUNT.
REQ-008 SHALL have port cfg_wdata_i  input  32  write data; COUNT takes the low CntWidth bits.
REQ-009 SHALL have port fetch_valid_i  input  1  IF output holds a valid instruction.
REQ-010 SHALL have port fetch_ready_i  input  1  ID accepts that instruction.
REQ-011 SHALL have port fetch_addr_i  input  32  PC of the presented instruction.
REQ-012 SHALL have port flush_i  input  1  non-loop redirect (branch, jump, exception, debug) this cycle.
REQ-013 SHALL have port hwlp_jump_o  output  1  one-cycle redirect request to the IF PC mux.
REQ-014 SHALL have port hwlp_target_o  output  32  redirect address, valid while hwlp_jump_o is high.
REQ-015 SHALL have port hwlp_idx_o  output  $clog2(NumHwlp) (min 1)  channel that caused the jump.
REQ-016 SHALL have port hwlp_start_o, hwlp_end_o  output  NumHwlp x 32  per-channel start/end readback.
REQ-017 SHALL have port hwlp_cnt_o  output  NumHwlp x CntWidth  per-channel counter readback.

Function
REQ-018 SHALL define accept = fetch_valid_i & fetch_ready_i & ~flush_i.
REQ-019 SHALL treat channel i as active iff cnt[i] != 0.
REQ-020 SHALL flag a hit on channel i when accept, active, and fetch_addr_i matches end[i] (see REQ-032/033).
REQ-021 SHALL resolve multiple hits to the lowest channel index; only that channel is affected.
REQ-022 On a hit with cnt >= 2: SHALL decrement cnt and, next cycle, assert hwlp_jump_o for exactly one cycle, with hwlp_target_o = start[i] and hwlp_idx_o = i.
REQ-023 On a hit with cnt == 1: SHALL decrement to 0 and assert no jump (fall-through exit).
REQ-024 A cfg write to COUNT of a channel SHALL take priority over a same-cycle decrement of that channel; the write value is kept.
REQ-025 A cfg write to START/END SHALL take effect for hits evaluated from the following cycle.
REQ-026 flush_i high in the cycle hwlp_jump_o is high SHALL NOT cancel the jump; the consumer gives flush priority, and the counter is not restored.
REQ-027 The counter SHALL NOT wrap: no decrement at 0.
REQ-028 Latency: one cycle from accepting the last loop instruction to hwlp_jump_o.
REQ-029 hwlp_target_o and hwlp_idx_o SHALL hold their last value when hwlp_jump_o is low.

Reset
REQ-030 On rst_i high at a clock edge, all start, end, and cnt registers SHALL be 0, and hwlp_jump_o, hwlp_target_o, and hwlp_idx_o SHALL be 0.
REQ-031 A reset asserted while a jump is pending SHALL drop that jump; no jump SHALL be output in the following cycle.

Configuration
REQ-032 With CVE2_HWLP_COMPRESSED_EN defined, the end match SHALL compare fetch_addr_i[31:1] with end[31:1]; half-word end addresses are legal.
REQ-033 Without CVE2_HWLP_COMPRESSED_EN, the match SHALL compare bits [31:2] only; end[1:0] and start[1:0] SHALL read back as 0.

Structure
REQ-034 cve2_pkg SHALL hold the hwlp_reg_e enum (HWLP_START, HWLP_END, HWLP_COUNT) and the PC_HWLP select encoding used by the IF mux.
REQ-035 The block SHALL instantiate NumHwlp copies of sub-module cve2_hwlp_channel, each holding start, end, and cnt registers plus hit logic; the top holds the priority select and the output register.

Verification
REQ-036 start=0x100, end=0x10C, cnt=3; accept 0x100..0x10C in a loop -> jumps to 0x100 on passes 1 and 2; pass 3 falls through with cnt=0.
REQ-037 Nested loops: ch0 end=0x110 cnt=2 and ch1 end=0x110 cnt=5; a hit at 0x110 -> hwlp_idx_o=0, ch1 unchanged.
REQ-038 Hit at end with flush_i=1 -> no decrement and no jump; a repeat hit with flush_i=0 -> jump.
REQ-039 cfg COUNT write of 7 in the same cycle as a decrementing hit -> cnt=7; the jump is still issued.
REQ-040 rst_i in the cycle after a hit -> hwlp_jump_o stays 0 and all counters read 0.
REQ-041 end=0x112 with the macro defined -> a hit at 0x112; without the macro -> a hit at 0x110.
